// File: rtl/delay_buffer_fsm.sv
// Packet-domain circular delay line on a single-port RAM. Each accepted packet is
// written, then the packet D slots older is read back and presented with a strobe.
module delay_buffer_fsm #(
  parameter int BUF_DEPTH  = 4410,
  parameter int AVG_DELAY  = 4,
  parameter int PKT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PKT_WIDTH-1:0]  pkt_reg_i,
  input  logic                  pktChanged_reg_i,
  input  logic [ADDR_WIDTH-1:0] extraDelay_reg_i,
  output logic [PKT_WIDTH-1:0]  pktDelayed_reg_o,
  output logic                  pktDelayedChanged_reg_o
);

  localparam int                  MEM_AW = $clog2(BUF_DEPTH);
  localparam logic [ADDR_WIDTH:0]   L_DEPTH = (ADDR_WIDTH+1)'(BUF_DEPTH);
  localparam logic [ADDR_WIDTH:0]   L_MAXD  = (ADDR_WIDTH+1)'(BUF_DEPTH-1);
  localparam logic [ADDR_WIDTH:0]   L_AVG   = (ADDR_WIDTH+1)'(AVG_DELAY);
  localparam logic [ADDR_WIDTH-1:0] L_LAST  = ADDR_WIDTH'(BUF_DEPTH-1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_CAPTURE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_accept;
  logic [PKT_WIDTH-1:0]  r_pkt;
  logic [ADDR_WIDTH-1:0] r_delay;
  logic [ADDR_WIDTH-1:0] r_writeAddr;
  logic [ADDR_WIDTH-1:0] r_writeAddrOld;
  logic [ADDR_WIDTH:0]   r_fill;
  logic                  r_masked;
  logic                  r_spramDOValid;
  logic [PKT_WIDTH-1:0]  r_spramDO;
  logic [ADDR_WIDTH-1:0] w_readAddr;
  logic [ADDR_WIDTH-1:0] w_ramAddr;
  logic [PKT_WIDTH-1:0]  r_mem [0:BUF_DEPTH-1];

  // Total delay, widened by one bit so the sum cannot overflow before clamping.
  function automatic logic [ADDR_WIDTH-1:0] clamp_delay(input logic [ADDR_WIDTH-1:0] extra);
    logic [ADDR_WIDTH:0] sum;
    sum = L_AVG + {1'b0, extra};
    if (sum > L_MAXD) sum = L_MAXD;
    return sum[ADDR_WIDTH-1:0];
  endfunction

  // Modular subtraction over a buffer that need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] wrap_sub(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [ADDR_WIDTH-1:0] d);
    logic [ADDR_WIDTH:0] t;
    if (a >= d) t = {1'b0, a} - {1'b0, d};
    else        t = {1'b0, a} + L_DEPTH - {1'b0, d};
    return t[ADDR_WIDTH-1:0];
  endfunction

  assign w_readAddr = wrap_sub(r_writeAddrOld, r_delay);
  assign w_ramAddr  = (r_state == S_WRITE) ? r_writeAddr : w_readAddr;

  generate
    if (MEM_AW < ADDR_WIDTH) begin : g_addr_hi
      logic w_unused_hi;
      assign w_unused_hi = ^w_ramAddr[ADDR_WIDTH-1:MEM_AW];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // CAPTURE also accepts a strobe so packets can arrive every third cycle.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pktChanged_reg_i) begin
          w_accept = 1'b1;
          w_next   = S_WRITE;
        end
      end
      S_WRITE: w_next = S_READ;
      S_READ:  w_next = S_CAPTURE;
      S_CAPTURE: begin
        if (pktChanged_reg_i) begin
          w_accept = 1'b1;
          w_next   = S_WRITE;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == S_WRITE) r_mem[w_ramAddr[MEM_AW-1:0]] <= r_pkt;
    if (r_state == S_READ)  r_spramDO <= r_mem[w_ramAddr[MEM_AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt                   <= '0;
      r_delay                 <= '0;
      r_writeAddr             <= '0;
      r_writeAddrOld          <= '0;
      r_fill                  <= '0;
      r_masked                <= 1'b0;
      r_spramDOValid          <= 1'b0;
      pktDelayed_reg_o        <= '0;
      pktDelayedChanged_reg_o <= 1'b0;
    end else begin
      pktDelayedChanged_reg_o <= 1'b0;
      if (w_accept) begin
        r_pkt   <= pkt_reg_i;
        r_delay <= clamp_delay(extraDelay_reg_i);
      end
      case (r_state)
        S_WRITE: begin
          r_writeAddrOld <= r_writeAddr;
          r_writeAddr    <= (r_writeAddr == L_LAST) ? '0 : r_writeAddr + 1'b1;
          if (r_fill != L_DEPTH) r_fill <= r_fill + 1'b1;
          // Fewer than D packets stored so far: the slot holds stale data.
          r_masked       <= (r_fill < {1'b0, r_delay});
        end
        S_READ: r_spramDOValid <= 1'b1;
        S_CAPTURE: begin
          pktDelayed_reg_o        <= r_masked ? '0 : r_spramDO;
          pktDelayedChanged_reg_o <= r_spramDOValid;
          r_spramDOValid          <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_buffer_fsm.sv
// Bench for delay_buffer_fsm: a large default instance and a small 8-slot instance
// share the stimulus; outputs are compared against a packet-history reference model.
module tb_delay_buffer_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pkt;
  logic        stb;
  logic [13:0] extra;
  logic [6:0]  extra_b;
  logic [15:0] ya, yb;
  logic        sa, sb;

  assign extra_b = extra[6:0];

  always #5 clk = ~clk;

  delay_buffer_fsm dut_a (
    .clk(clk), .rst(rst), .pkt_reg_i(pkt), .pktChanged_reg_i(stb),
    .extraDelay_reg_i(extra), .pktDelayed_reg_o(ya), .pktDelayedChanged_reg_o(sa));

  delay_buffer_fsm #(.BUF_DEPTH(8), .AVG_DELAY(0), .PKT_WIDTH(16), .ADDR_WIDTH(7)) dut_b (
    .clk(clk), .rst(rst), .pkt_reg_i(pkt), .pktChanged_reg_i(stb),
    .extraDelay_reg_i(extra_b), .pktDelayed_reg_o(yb), .pktDelayedChanged_reg_o(sb));

  typedef struct { logic [15:0] d; int c; } ev_t;

  ev_t         got_a[$], got_b[$], exp_a[$], exp_b[$];
  ev_t         ev_mon, ev_drv;
  logic [15:0] hist_a[$], hist_b[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  logic [15:0] basic_in[9]  = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE,
                                16'hFFFF, 16'h1234, 16'h5678, 16'h9999};
  logic [15:0] basic_exp[9] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
  logic [15:0] zero_in[5]   = '{16'h1234, 16'hBEEF, 16'h0001, 16'hFFFF, 16'h8000};

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sa === 1'b1) begin ev_mon.d = ya; ev_mon.c = cyc; got_a.push_back(ev_mon); end
    if (sb === 1'b1) begin ev_mon.d = yb; ev_mon.c = cyc; got_b.push_back(ev_mon); end
  end

  // Output for packet n is packet n-D of the history since reset, or 0 if n < D.
  function automatic logic [15:0] model_a(input logic [15:0] p, input int e);
    int d, n;
    d = 4 + e;
    if (d > 4409) d = 4409;
    hist_a.push_back(p);
    n = hist_a.size() - 1;
    return (n < d) ? 16'h0000 : hist_a[n-d];
  endfunction

  function automatic logic [15:0] model_b(input logic [15:0] p, input int e);
    int d, n;
    d = e;
    if (d > 7) d = 7;
    hist_b.push_back(p);
    n = hist_b.size() - 1;
    return (n < d) ? 16'h0000 : hist_b[n-d];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_q();
    got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; stb = 1'b0; pkt = '0; extra = '0;
    repeat (3) tick();
    rst = 1'b0;
    hist_a.delete(); hist_b.delete();
    tick();
    clear_q();
  endtask

  task automatic send(input logic [15:0] p, input int e, input int gap);
    pkt = p; extra = e[13:0]; stb = 1'b1;
    tick();
    stb = 1'b0;
    ev_drv.c = cyc + 3;
    ev_drv.d = model_a(p, e); exp_a.push_back(ev_drv);
    ev_drv.d = model_b(p, e); exp_b.push_back(ev_drv);
    repeat (gap - 1) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; stb = 1'b0; pkt = '0; extra = '0;
    repeat (5) tick();
    n_tests += 7;
    if (ya !== 16'h0) begin n_fail++; $display("FAIL rst_ya: got %h, expected 0000", ya); end
    if (sa !== 1'b0)  begin n_fail++; $display("FAIL rst_sa: got %b, expected 0", sa); end
    if (yb !== 16'h0) begin n_fail++; $display("FAIL rst_yb: got %h, expected 0000", yb); end
    if (sb !== 1'b0)  begin n_fail++; $display("FAIL rst_sb: got %b, expected 0", sb); end
    if (dut_a.r_writeAddr !== '0)
      begin n_fail++; $display("FAIL rst_waddr: got %0d, expected 0", dut_a.r_writeAddr); end
    if (dut_a.r_writeAddrOld !== '0)
      begin n_fail++; $display("FAIL rst_waddr_old: got %0d, expected 0", dut_a.r_writeAddrOld); end
    if (dut_a.r_spramDOValid !== 1'b0)
      begin n_fail++; $display("FAIL rst_dovalid: got %b, expected 0", dut_a.r_spramDOValid); end
    rst = 1'b0;
    hist_a.delete(); hist_b.delete(); clear_q();
    repeat (5) tick();
    n_tests += 2;
    if (ya !== 16'h0 || yb !== 16'h0)
      begin n_fail++; $display("FAIL idle_out: got %h/%h, expected 0000/0000", ya, yb); end
    if (got_a.size() != 0 || got_b.size() != 0)
      begin n_fail++; $display("FAIL idle_stb: got %0d/%0d pulses, expected 0/0", got_a.size(), got_b.size()); end
  endtask

  task automatic test_basic_delay();
    do_reset();
    for (int i = 0; i < 9; i++) send(basic_in[i], 1, 4);
    repeat (6) tick();
    n_tests++;
    if (got_a.size() != 9) begin n_fail++; $display("FAIL basic_count: got %0d, expected 9", got_a.size()); end
    for (int i = 0; i < 9; i++) begin
      n_tests++;
      if (i >= got_a.size() || got_a[i].d !== basic_exp[i] || got_a[i].c !== exp_a[i].c) begin
        n_fail++;
        $display("FAIL basic[%0d]: got %h at cycle %0d, expected %h at cycle %0d",
                 i, got_a[i].d, got_a[i].c, basic_exp[i], exp_a[i].c);
      end
    end
  endtask

  task automatic test_zero_delay();
    clear_q();
    for (int i = 0; i < 5; i++) send(zero_in[i], 0, 4);
    repeat (6) tick();
    n_tests++;
    if (got_b.size() != 5) begin n_fail++; $display("FAIL zero_count: got %0d, expected 5", got_b.size()); end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (i >= got_b.size() || got_b[i].d !== zero_in[i] || got_b[i].c !== exp_b[i].c) begin
        n_fail++;
        $display("FAIL zero[%0d]: got %h at cycle %0d, expected %h at cycle %0d",
                 i, got_b[i].d, got_b[i].c, zero_in[i], exp_b[i].c);
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] want;
    do_reset();
    for (int k = 0; k < 20; k++) send(16'h1000 + 16'(k), 3, 4);
    repeat (6) tick();
    n_tests++;
    if (got_b.size() != 20) begin n_fail++; $display("FAIL wrap_count: got %0d, expected 20", got_b.size()); end
    for (int k = 0; k < 20; k++) begin
      want = (k >= 3) ? 16'h1000 + 16'(k - 3) : 16'h0000;
      n_tests++;
      if (k >= got_b.size() || got_b[k].d !== want) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %h, expected %h", k, got_b[k].d, want);
      end
    end
  endtask

  task automatic test_clamp();
    clear_q();
    for (int i = 0; i < 12; i++) send(16'h2000 + 16'(i), 100, 3);
    repeat (6) tick();
    n_tests++;
    if (got_b.size() != 12) begin n_fail++; $display("FAIL clamp_count: got %0d, expected 12", got_b.size()); end
    for (int i = 0; i < 12; i++) begin
      n_tests++;
      if (i >= got_b.size() || got_b[i].d !== exp_b[i].d || got_b[i].c !== exp_b[i].c) begin
        n_fail++;
        $display("FAIL clamp[%0d]: got %h at cycle %0d, expected %h at cycle %0d",
                 i, got_b[i].d, got_b[i].c, exp_b[i].d, exp_b[i].c);
      end
    end
  endtask

  task automatic test_back_to_back(input string name, input int npkt, input int emax,
                                   input int gmin, input int gmax);
    clear_q();
    for (int i = 0; i < npkt; i++)
      send(16'($urandom), $urandom_range(0, emax), $urandom_range(gmin, gmax));
    repeat (6) tick();
    n_tests += 2;
    if (got_a.size() != exp_a.size())
      begin n_fail++; $display("FAIL %s_count_a: got %0d, expected %0d", name, got_a.size(), exp_a.size()); end
    if (got_b.size() != exp_b.size())
      begin n_fail++; $display("FAIL %s_count_b: got %0d, expected %0d", name, got_b.size(), exp_b.size()); end
    for (int i = 0; i < exp_a.size(); i++) begin
      n_tests += 2;
      if (i >= got_a.size() || got_a[i].d !== exp_a[i].d || got_a[i].c !== exp_a[i].c) begin
        n_fail++;
        $display("FAIL %s_a[%0d]: got %h at cycle %0d, expected %h at cycle %0d",
                 name, i, got_a[i].d, got_a[i].c, exp_a[i].d, exp_a[i].c);
      end
      if (i >= got_b.size() || got_b[i].d !== exp_b[i].d || got_b[i].c !== exp_b[i].c) begin
        n_fail++;
        $display("FAIL %s_b[%0d]: got %h at cycle %0d, expected %h at cycle %0d",
                 name, i, got_b[i].d, got_b[i].c, exp_b[i].d, exp_b[i].c);
      end
    end
  endtask

  task automatic test_busy();
    clear_q();
    pkt = 16'h7111; extra = 14'd1; stb = 1'b1;
    tick();
    ev_drv.c = cyc + 3;
    ev_drv.d = model_a(16'h7111, 1); exp_a.push_back(ev_drv);
    ev_drv.d = model_b(16'h7111, 1); exp_b.push_back(ev_drv);
    pkt = 16'h7222;
    tick();
    stb = 1'b0;
    tick();
    send(16'h7333, 1, 4);
    repeat (6) tick();
    n_tests += 3;
    if (got_b.size() != 2) begin n_fail++; $display("FAIL busy_count: got %0d, expected 2", got_b.size()); end
    if (got_b.size() > 1 && got_b[1].d !== 16'h7111)
      begin n_fail++; $display("FAIL busy_drop: got %h, expected 7111", got_b[1].d); end
    if (got_b.size() > 0 && got_b[0].c !== exp_b[0].c)
      begin n_fail++; $display("FAIL busy_lat: got cycle %0d, expected %0d", got_b[0].c, exp_b[0].c); end
  endtask

  task automatic test_reset_in_read();
    clear_q();
    pkt = 16'h5A5A; extra = 14'd0; stb = 1'b1;
    tick();
    stb = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_tests += 4;
    if (dut_b.r_spramDOValid !== 1'b0 || dut_b.r_writeAddr !== '0 || dut_b.r_writeAddrOld !== '0)
      begin n_fail++; $display("FAIL rr_state_b: got %b/%0d/%0d, expected 0/0/0",
                               dut_b.r_spramDOValid, dut_b.r_writeAddr, dut_b.r_writeAddrOld); end
    if (dut_a.r_writeAddr !== '0 || dut_a.r_fill !== '0)
      begin n_fail++; $display("FAIL rr_state_a: got %0d/%0d, expected 0/0", dut_a.r_writeAddr, dut_a.r_fill); end
    if (ya !== 16'h0 || yb !== 16'h0)
      begin n_fail++; $display("FAIL rr_out: got %h/%h, expected 0000/0000", ya, yb); end
    repeat (4) tick();
    if (got_a.size() != 0 || got_b.size() != 0)
      begin n_fail++; $display("FAIL rr_pulse: got %0d/%0d, expected 0/0", got_a.size(), got_b.size()); end
    rst = 1'b0;
    hist_a.delete(); hist_b.delete();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_delay();
    test_zero_delay();
    test_wrap();
    test_clamp();
    test_busy();
    test_reset_in_read();
    test_back_to_back("b2b", 15, 5, 3, 3);
    test_back_to_back("rand", 60, 12, 3, 6);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
